// File: rtl/mem_stage_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_lsu_pkg
//  Description : Shared encodings and bus-width helpers for the MEM-stage LSU
//                (load opcodes, stall polarity, FSM state encodings).
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_lsu_pkg;

    // Load opcode encoding carried in the EX->MEM bus ld_op field
    localparam logic [2:0] c_LD_LB  = 3'd0;
    localparam logic [2:0] c_LD_LBU = 3'd1;
    localparam logic [2:0] c_LD_LH  = 3'd2;
    localparam logic [2:0] c_LD_LHU = 3'd3;
    localparam logic [2:0] c_LD_LW  = 3'd4;

    // Stall vector polarity
    localparam logic c_STOP    = 1'b1;
    localparam logic c_NO_STOP = 1'b0;

    // FSM state encodings
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;
    localparam logic [1:0] c_ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = c_ST_IDLE,
        S_WAIT  = c_ST_WAIT,
        S_DONE  = c_ST_DONE,
        S_DRAIN = c_ST_DRAIN
    } lsu_state_e;

    // EX->MEM bus: {pc, ld_op, addr_lo, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
    function automatic int ex_width(input int data_w, input int pc_w);
        return pc_w + 3 + 2 + 1 + (data_w / 8) + 1 + 1 + 5 + data_w;
    endfunction

    // MEM->WB bus: {pc, rf_we, rf_waddr, rf_wdata}
    function automatic int wb_width(input int data_w, input int pc_w);
        return pc_w + 1 + 5 + data_w;
    endfunction

endpackage : mem_stage_lsu_pkg
`default_nettype wire

// File: rtl/mem_stage_lsu_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Combinational load alignment: picks the byte/half/word named
//                by ld_op and addr_lo out of a raw memory word and sign- or
//                zero-extends it to DATA_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import mem_stage_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        ld_op,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection; halves ignore addr_lo[0] so a misaligned half reads the enclosing half
    assign w_byte = raw[{addr_lo, 3'b000} +: 8];
    assign w_half = raw[{addr_lo[1], 4'b0000} +: 16];

    // Extension by opcode; unknown opcodes pass the word through
    always_comb begin
        data = raw;
        case (ld_op)
            c_LD_LB:  data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            c_LD_LBU: data = {{(DATA_W-8){1'b0}}, w_byte};
            c_LD_LH:  data = {{(DATA_W-16){w_half[15]}}, w_half};
            c_LD_LHU: data = {{(DATA_W-16){1'b0}}, w_half};
            default:  data = raw;
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_lsu
//  Description : MEM pipeline stage. Registers the EX->MEM bus, waits on the
//                data-memory response for loads (raising a stall request while
//                waiting), aligns load data and drives the MEM->WB bus and the
//                MEM-stage forwarding outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int PC_W      = 32,
    parameter  int STALL_W   = 6,
    parameter  int STAGE_IDX = 3,
    localparam int EX_W      = ex_width(DATA_W, PC_W),
    localparam int WB_W      = wb_width(DATA_W, PC_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [STALL_W-1:0]  stall,
    input  logic [EX_W-1:0]     ex_to_mem_bus,
    input  logic                data_rvalid,
    input  logic [DATA_W-1:0]   data_rdata,
    output logic [WB_W-1:0]     mem_to_wb_bus,
    output logic                stallreq_mem,
    output logic                fwd_we,
    output logic [4:0]          fwd_waddr,
    output logic [DATA_W-1:0]   fwd_wdata
);

    localparam int c_NB = DATA_W / 8;

    logic [EX_W-1:0]    r_bus;
    lsu_state_e         r_state;
    logic [DATA_W-1:0]  r_hold;

    logic [PC_W-1:0]    w_pc;
    logic [2:0]         w_ld_op;
    logic [1:0]         w_addr_lo;
    logic               w_ram_en;
    logic [c_NB-1:0]    w_ram_wen;
    logic               w_sel_rf_res;
    logic               w_rf_we;
    logic [4:0]         w_rf_waddr;
    logic [DATA_W-1:0]  w_ex_result;
    logic               w_is_load;
    logic               w_stage_stop;
    logic               w_next_stop;
    logic [DATA_W-1:0]  w_src;
    logic [DATA_W-1:0]  w_ld_data;
    logic [DATA_W-1:0]  w_rf_wdata;

    // Field decode of the registered EX->MEM bus
    assign {w_pc, w_ld_op, w_addr_lo, w_ram_en, w_ram_wen,
            w_sel_rf_res, w_rf_we, w_rf_waddr, w_ex_result} = r_bus;

    assign w_is_load    = w_ram_en && (w_ram_wen == '0);
    assign w_stage_stop = (stall[STAGE_IDX]   == c_STOP);
    assign w_next_stop  = (stall[STAGE_IDX+1] == c_STOP);

    // EX->MEM register: flush, then bubble when WB moves on without us, then capture, else hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus <= '0;
        end else if (flush) begin
            r_bus <= '0;
        end else if (w_stage_stop && !w_next_stop) begin
            r_bus <= '0;
        end else if (!w_stage_stop) begin
            r_bus <= ex_to_mem_bus;
        end
    end

    // Load-response FSM and hold register for data that arrived while the stage was stopped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_hold <= '0;
                    end else if (w_is_load && !data_rvalid) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        // A response in the flush cycle belongs to the killed load
                        r_state <= data_rvalid ? S_IDLE : S_DRAIN;
                    end else if (data_rvalid) begin
                        r_hold  <= data_rdata;
                        r_state <= w_stage_stop ? S_DONE : S_IDLE;
                    end
                end
                S_DONE: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_hold  <= '0;
                    end else if (!w_stage_stop) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    // The outstanding response is for a flushed load; swallow it
                    if (data_rvalid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stall request: a load is outstanding, or a stale response is still to be drained
    always_comb begin
        stallreq_mem = 1'b0;
        case (r_state)
            S_IDLE, S_WAIT: stallreq_mem = w_is_load && !data_rvalid;
            S_DRAIN:        stallreq_mem = w_is_load;
            default:        stallreq_mem = 1'b0;
        endcase
    end

    assign w_src = (r_state == S_DONE) ? r_hold : data_rdata;

    load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .ld_op   (w_ld_op),
        .addr_lo (w_addr_lo),
        .raw     (w_src),
        .data    (w_ld_data)
    );

    assign w_rf_wdata    = w_sel_rf_res ? w_ld_data : w_ex_result;

    assign mem_to_wb_bus = {w_pc, w_rf_we, w_rf_waddr, w_rf_wdata};
    assign fwd_we        = w_rf_we && !stallreq_mem;
    assign fwd_waddr     = w_rf_waddr;
    assign fwd_wdata     = w_rf_wdata;

endmodule : mem_stage_lsu
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_lsu
//  Description : Scoreboard bench for mem_stage_lsu. Directed stimulus pushes
//                hand-computed MEM->WB words; a monitor compares them whenever
//                the stage presents a forwardable result.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    localparam int c_DW   = 32;
    localparam int c_PW   = 32;
    localparam int c_SW   = 6;
    localparam int c_EX_W = ex_width(c_DW, c_PW);
    localparam int c_WB_W = wb_width(c_DW, c_PW);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               flush = 1'b0;
    logic [c_SW-1:0]    ext_stall = '0;
    logic [c_SW-1:0]    stall;
    logic [c_EX_W-1:0]  ex_bus = '0;
    logic               data_rvalid = 1'b0;
    logic [c_DW-1:0]    data_rdata = '0;
    logic [c_WB_W-1:0]  mem_to_wb_bus;
    logic               stallreq_mem;
    logic               fwd_we;
    logic [4:0]         fwd_waddr;
    logic [c_DW-1:0]    fwd_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [c_WB_W-1:0]  exp_q[$];
    string              name_q[$];

    // Pipeline controller model: a MEM stall request stops MEM and holds WB's input
    assign stall = ext_stall | {1'b0, stallreq_mem, stallreq_mem, 3'b000};

    always #5 clk = ~clk;

    mem_stage_lsu #(
        .DATA_W    (c_DW),
        .PC_W      (c_PW),
        .STALL_W   (c_SW),
        .STAGE_IDX (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .stall         (stall),
        .ex_to_mem_bus (ex_bus),
        .data_rvalid   (data_rvalid),
        .data_rdata    (data_rdata),
        .mem_to_wb_bus (mem_to_wb_bus),
        .stallreq_mem  (stallreq_mem),
        .fwd_we        (fwd_we),
        .fwd_waddr     (fwd_waddr),
        .fwd_wdata     (fwd_wdata)
    );

    task automatic chk(input string nm, input logic [c_WB_W-1:0] act, input logic [c_WB_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [c_EX_W-1:0] mk(input logic [31:0] pc, input logic [2:0] ld,
                                             input logic [1:0] alo, input logic en,
                                             input logic [3:0] wen, input logic sel,
                                             input logic we, input logic [4:0] wa,
                                             input logic [31:0] res);
        return {pc, ld, alo, en, wen, sel, we, wa, res};
    endfunction

    function automatic logic [c_WB_W-1:0] wb(input logic [31:0] pc, input logic [4:0] wa,
                                            input logic [31:0] d);
        return {pc, 1'b1, wa, d};
    endfunction

    // Monitor: compare the head entry whenever a result is forwardable; pop when it advances
    initial begin
        forever begin
            @(negedge clk);
            if (fwd_we && !rst) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h expected none", mem_to_wb_bus);
                end else begin
                    chk(name_q[0], mem_to_wb_bus, exp_q[0]);
                    chk({name_q[0], "_fwd"}, {c_PW'(0), 1'b0, fwd_waddr, fwd_wdata},
                        {c_PW'(0), 1'b0, exp_q[0][c_DW+4:c_DW], exp_q[0][c_DW-1:0]});
                    if (stall[3] == c_NO_STOP) begin
                        void'(exp_q.pop_front());
                        void'(name_q.pop_front());
                    end
                end
            end
        end
    end

    // Issue one op at posedge+1; lat cycles of stall request, then the response cycle
    task automatic run_op(input string nm, input logic [c_EX_W-1:0] op, input bit push,
                          input logic [c_WB_W-1:0] exp, input int lat,
                          input logic rv, input logic [31:0] rd);
        ex_bus = op;
        if (push) begin
            exp_q.push_back(exp);
            name_q.push_back(nm);
        end
        @(posedge clk); #1;
        ex_bus = '0;
        for (int i = 0; i < lat; i++) begin
            data_rvalid = 1'b0;
            #1 chk({nm, "_stallreq_wait"}, c_WB_W'(stallreq_mem), c_WB_W'(1));
            @(posedge clk); #1;
        end
        data_rvalid = rv;
        data_rdata  = rd;
        #1 chk({nm, "_stallreq_done"}, c_WB_W'(stallreq_mem), c_WB_W'(0));
        @(posedge clk); #1;
        data_rvalid = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        chk("reset_wb_bus", mem_to_wb_bus, '0);
        chk("reset_fwd", {stallreq_mem, fwd_we, fwd_waddr, fwd_wdata}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: LW with same-cycle response
        run_op("lw_hit", mk(32'h100, c_LD_LW, 2'd0, 1'b1, 4'h0, 1'b1, 1'b1, 5'd1, 32'h1000),
               1'b1, wb(32'h100, 5'd1, 32'hDEADBEEF), 0, 1'b1, 32'hDEADBEEF);

        // 2: byte loads at lane 3 with 3-cycle latency
        run_op("lb_lat3", mk(32'h104, c_LD_LB, 2'd3, 1'b1, 4'h0, 1'b1, 1'b1, 5'd2, 32'h1003),
               1'b1, wb(32'h104, 5'd2, 32'hFFFFFF80), 3, 1'b1, 32'h80000000);
        run_op("lbu_lat3", mk(32'h108, c_LD_LBU, 2'd3, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3, 32'h1003),
               1'b1, wb(32'h108, 5'd3, 32'h00000080), 3, 1'b1, 32'h80000000);

        // 3: half loads from the upper half, addr_lo[0] ignored
        run_op("lh_a2", mk(32'h10C, c_LD_LH, 2'd2, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4, 32'h1002),
               1'b1, wb(32'h10C, 5'd4, 32'hFFFF8001), 1, 1'b1, 32'h80017FFF);
        run_op("lhu_a2", mk(32'h110, c_LD_LHU, 2'd2, 1'b1, 4'h0, 1'b1, 1'b1, 5'd5, 32'h1002),
               1'b1, wb(32'h110, 5'd5, 32'h00008001), 0, 1'b1, 32'h80017FFF);
        run_op("lh_a3", mk(32'h114, c_LD_LH, 2'd3, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6, 32'h1003),
               1'b1, wb(32'h114, 5'd6, 32'hFFFF8001), 0, 1'b1, 32'h80017FFF);
        run_op("lh_a0", mk(32'h118, c_LD_LH, 2'd0, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, 32'h1000),
               1'b1, wb(32'h118, 5'd7, 32'h00007FFF), 0, 1'b1, 32'h80017FFF);

        // Store never waits, ALU result bypasses the load path
        run_op("store", mk(32'h11C, c_LD_LW, 2'd0, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h2000),
               1'b0, '0, 0, 1'b0, 32'h0);
        run_op("alu", mk(32'h120, c_LD_LB, 2'd3, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'h0BADF00D),
               1'b1, wb(32'h120, 5'd8, 32'h0BADF00D), 0, 1'b0, 32'hFFFFFFFF);

        // 4: flush during WAIT, stale response drained, new LW waits for its own data
        ex_bus = mk(32'h200, c_LD_LW, 2'd0, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h3000);
        @(posedge clk); #1;
        ex_bus = '0;
        #1 chk("flush_pre_stallreq", c_WB_W'(stallreq_mem), c_WB_W'(1));
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        #1 chk("flush_killed_bus", mem_to_wb_bus, '0);
        ex_bus = mk(32'h204, c_LD_LW, 2'd0, 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h3004);
        exp_q.push_back(wb(32'h204, 5'd10, 32'h12345678));
        name_q.push_back("lw_after_drain");
        @(posedge clk); #1;
        ex_bus      = '0;
        data_rvalid = 1'b1;
        data_rdata  = 32'hBAD0BAD0;
        #1 chk("drain_stale_stallreq", c_WB_W'(stallreq_mem), c_WB_W'(1));
        @(posedge clk); #1;
        data_rvalid = 1'b0;
        #1 chk("post_drain_stallreq", c_WB_W'(stallreq_mem), c_WB_W'(1));
        @(posedge clk); #1;
        data_rvalid = 1'b1;
        data_rdata  = 32'h12345678;
        #1 chk("own_rvalid_stallreq", c_WB_W'(stallreq_mem), c_WB_W'(0));
        @(posedge clk); #1;
        data_rvalid = 1'b0;

        // 5: response arrives while stopped externally; result held from the hold register
        ex_bus = mk(32'h300, c_LD_LW, 2'd0, 1'b1, 4'h0, 1'b1, 1'b1, 5'd11, 32'h4000);
        exp_q.push_back(wb(32'h300, 5'd11, 32'hCAFEF00D));
        name_q.push_back("lw_done_hold");
        @(posedge clk); #1;
        ex_bus = '0;
        @(posedge clk); #1;
        ext_stall   = 6'b011000;
        data_rvalid = 1'b1;
        data_rdata  = 32'hCAFEF00D;
        @(posedge clk); #1;
        data_rvalid = 1'b0;
        data_rdata  = 32'h11111111;
        @(posedge clk); #1;
        data_rdata  = 32'h22222222;
        @(posedge clk); #1;
        ext_stall = '0;
        @(posedge clk); #1;
        chk("done_released_bus", mem_to_wb_bus, '0);

        // 6: asynchronous reset mid-WAIT clears outputs without a clock edge
        ex_bus = mk(32'h400, c_LD_LW, 2'd0, 1'b1, 4'h0, 1'b1, 1'b1, 5'd12, 32'h5000);
        @(posedge clk); #1;
        ex_bus = '0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1 chk("async_rst_wb_bus", mem_to_wb_bus, '0);
        chk("async_rst_fwd", {stallreq_mem, fwd_we, fwd_waddr, fwd_wdata}, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // After reset the FSM is IDLE: a same-cycle hit completes with no stall
        run_op("lw_after_rst", mk(32'h404, c_LD_LW, 2'd0, 1'b1, 4'h0, 1'b1, 1'b1, 5'd13, 32'h5004),
               1'b1, wb(32'h404, 5'd13, 32'h0F0F0F0F), 0, 1'b1, 32'h0F0F0F0F);

        // Bubble: MEM stopped, WB running -> register loads zeros, rf_we low
        ex_bus = mk(32'h500, c_LD_LW, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd14, 32'h000000AA);
        exp_q.push_back(wb(32'h500, 5'd14, 32'h000000AA));
        name_q.push_back("alu_before_bubble");
        @(posedge clk); #6;
        ext_stall = 6'b001000;
        ex_bus    = mk(32'h504, c_LD_LW, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd15, 32'h000000BB);
        @(posedge clk); #1;
        chk("bubble_wb_bus", mem_to_wb_bus, '0);
        chk("bubble_fwd_we", c_WB_W'(fwd_we), c_WB_W'(0));
        ext_stall = '0;
        ex_bus    = '0;
        repeat (3) @(posedge clk);
        #1;

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_stage_lsu
`default_nettype wire
